// File: rtl/bus_dev_fifo.sv
// Bus-attached device: a host-to-bus TX FIFO and an address-filtered bus-to-host RX FIFO,
// both first-word-fall-through, with sticky overflow flags and a saturating drop counter.

module bus_dev_fifo_buf #(
    parameter int width = 32,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr,
    input  logic [width-1:0]             wdata,
    input  logic                         rd,
    output logic [width-1:0]             head,
    output logic                         nonempty,
    output logic                         full,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         wr_drop
);
    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    localparam logic [cw-1:0] full_count = cw'(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign nonempty = (count != '0);
    assign full     = (count == full_count);
    // A pop frees a slot in the same edge, so a write to a full FIFO still lands when paired with a pop.
    assign rd_ok    = rd && nonempty;
    assign wr_ok    = wr && (!full || rd_ok);
    assign wr_drop  = wr && !wr_ok;
    assign head     = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count gates visibility, so stale entries never appear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module bus_dev_fifo #(
    parameter int         pckg_sz   = 32,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                        clk,
    input  logic                        reset,
    // bus side
    output logic                        pndng,
    output logic [pckg_sz-1:0]          D_pop,
    input  logic                        pop,
    input  logic                        push,
    input  logic [pckg_sz-1:0]          D_push,
    // host side
    input  logic                        wr_en,
    input  logic [pckg_sz-1:0]          wr_data,
    output logic                        tx_full,
    input  logic                        rd_en,
    output logic [pckg_sz-1:0]          rd_data,
    output logic                        rx_valid,
    output logic [$clog2(depth+1)-1:0]  tx_count,
    output logic [$clog2(depth+1)-1:0]  rx_count,
    // status
    output logic                        tx_ovf,
    output logic                        rx_ovf,
    output logic [7:0]                  drop_cnt,
    input  logic                        err_clr
);
    logic [7:0] dest;
    logic       addr_hit;
    logic       rx_wr;
    logic       filtered;
    logic       tx_drop;
    logic       rx_drop;
    logic       rx_full;

    assign dest     = D_push[pckg_sz-1 -: 8];
    assign addr_hit = (dest == id) || (dest == broadcast);
    assign rx_wr    = push && addr_hit;
    assign filtered = push && !addr_hit;

    bus_dev_fifo_buf #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr_en),
        .wdata    (wr_data),
        .rd       (pop),
        .head     (D_pop),
        .nonempty (pndng),
        .full     (tx_full),
        .count    (tx_count),
        .wr_drop  (tx_drop)
    );

    bus_dev_fifo_buf #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .wr       (rx_wr),
        .wdata    (D_push),
        .rd       (rd_en),
        .head     (rd_data),
        .nonempty (rx_valid),
        .full     (rx_full),
        .count    (rx_count),
        .wr_drop  (rx_drop)
    );

    // A set or increment in the same cycle as err_clr takes priority over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (tx_drop)      tx_ovf <= 1'b1;
            else if (err_clr) tx_ovf <= 1'b0;

            if (rx_drop)      rx_ovf <= 1'b1;
            else if (err_clr) rx_ovf <= 1'b0;

            if (filtered) begin
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            end else if (err_clr) begin
                drop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Scoreboard bench for bus_dev_fifo: queue models of both FIFOs, heads compared as they are consumed.

module tb_bus_dev_fifo;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);
    localparam logic [7:0] MY_ID = 8'h03;

    logic          clk = 1'b0;
    logic          reset;
    logic          pndng, pop, push, wr_en, tx_full, rd_en, rx_valid;
    logic          tx_ovf, rx_ovf, err_clr;
    logic [W-1:0]  D_pop, D_push, wr_data, rd_data;
    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    drop_cnt;

    bus_dev_fifo #(.pckg_sz(W), .depth(D), .id(MY_ID), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_full  (tx_full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .tx_count (tx_count),
        .rx_count (rx_count),
        .tx_ovf   (tx_ovf),
        .rx_ovf   (rx_ovf),
        .drop_cnt (drop_cnt),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    bit           m_tx_ovf;
    bit           m_rx_ovf;
    int           m_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        m_tx_ovf = 0;
        m_rx_ovf = 0;
        m_drop   = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pndng"},    pndng,    txq.size() > 0);
        check({tag, ".tx_count"}, tx_count, txq.size());
        check({tag, ".tx_full"},  tx_full,  txq.size() == D);
        check({tag, ".rx_valid"}, rx_valid, rxq.size() > 0);
        check({tag, ".rx_count"}, rx_count, rxq.size());
        check({tag, ".tx_ovf"},   tx_ovf,   m_tx_ovf);
        check({tag, ".rx_ovf"},   rx_ovf,   m_rx_ovf);
        check({tag, ".drop_cnt"}, drop_cnt, m_drop);
        if (txq.size() > 0) check({tag, ".D_pop"},   D_pop,   txq[0]);
        if (rxq.size() > 0) check({tag, ".rd_data"}, rd_data, rxq[0]);
    endtask

    // One clock: drive inputs, score consumed heads, advance the model, then check after the edge.
    task automatic tick(input string tag, input bit w, input logic [W-1:0] wd, input bit p,
                        input bit ps, input logic [W-1:0] pd, input bit r, input bit clr);
        bit pop_ok, wr_ok, rd_ok, hit, set_tx, set_rx, inc_drop;
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = pd; rd_en = r; err_clr = clr;
        if (p && txq.size() > 0) check({tag, ".pop_head"}, D_pop, txq[0]);
        if (r && rxq.size() > 0) check({tag, ".rd_head"}, rd_data, rxq[0]);

        pop_ok = p && txq.size() > 0;
        wr_ok  = w && (txq.size() < D || pop_ok);
        set_tx = w && !wr_ok;
        hit    = ps && (pd[W-1 -: 8] == MY_ID || pd[W-1 -: 8] == 8'hFF);
        inc_drop = ps && !hit;
        rd_ok  = r && rxq.size() > 0;
        set_rx = hit && !(rxq.size() < D || rd_ok);
        if (pop_ok) void'(txq.pop_front());
        if (wr_ok) txq.push_back(wd);
        if (rd_ok) void'(rxq.pop_front());
        if (hit && !set_rx) rxq.push_back(pd);
        if (set_tx) m_tx_ovf = 1; else if (clr) m_tx_ovf = 0;
        if (set_rx) m_rx_ovf = 1; else if (clr) m_rx_ovf = 0;
        if (inc_drop) begin
            if (m_drop < 255) m_drop++;
        end else if (clr) m_drop = 0;

        @(posedge clk);
        #1;
        wr_en = 0; pop = 0; push = 0; rd_en = 0; err_clr = 0;
        check_state(tag);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [7:0]   dst;
        wr_en = 0; pop = 0; push = 0; rd_en = 0; err_clr = 0;
        wr_data = '0; D_push = '0;
        model_clear();

        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_state("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic TX ordering and empty-pop behaviour
        tick("tx_w1",  1, 32'h01AA_0001, 0, 0, '0, 0, 0);
        check("tx_w1.head", D_pop, 32'h01AA_0001);
        tick("tx_w2",  1, 32'h01AA_0002, 0, 0, '0, 0, 0);
        tick("tx_p1",  0, '0, 1, 0, '0, 0, 0);
        check("tx_p1.head", D_pop, 32'h01AA_0002);
        tick("tx_p2",  0, '0, 1, 0, '0, 0, 0);
        check("tx_p2.pndng", pndng, 1'b0);
        tick("tx_pe",  0, '0, 1, 0, '0, 1, 0);
        tick("tx_wpe", 1, 32'h0000_0BEE, 1, 0, '0, 0, 0);
        tick("tx_p3",  0, '0, 1, 0, '0, 0, 0);

        // TX fill to full plus one, write+pop at full, then clear
        for (int i = 0; i < D + 1; i++) tick("tx_fill", 1, 32'hA000_0000 + i, 0, 0, '0, 0, 0);
        check("tx_fill.count", tx_count, D);
        check("tx_fill.ovf", tx_ovf, 1'b1);
        tick("tx_wp_full", 1, 32'hB000_0001, 1, 0, '0, 0, 0);
        tick("tx_clr", 0, '0, 0, 0, '0, 0, 1);
        check("tx_clr.ovf", tx_ovf, 1'b0);
        for (int i = 0; i < D; i++) tick("tx_drain", 0, '0, 1, 0, '0, 0, 0);

        // RX address filter
        tick("rx_id",  0, '0, 0, 1, 32'h0312_3456, 0, 0);
        tick("rx_bc",  0, '0, 0, 1, 32'hFFAB_CDEF, 0, 0);
        tick("rx_oth", 0, '0, 0, 1, 32'h0500_0000, 0, 0);
        check("rx_filt.count", rx_count, 2);
        check("rx_filt.drop", drop_cnt, 1);
        check("rx_filt.head", rd_data, 32'h0312_3456);
        for (int i = 0; i < 3; i++) tick("rx_drain", 0, '0, 0, 0, '0, 1, 0);

        // Drop counter saturation, increment beats clear
        for (int i = 0; i < 256; i++) tick("drop", 0, '0, 0, 1, 32'h0700_0000 + i, 0, 0);
        check("drop.sat", drop_cnt, 8'd255);
        tick("drop_clr_inc", 0, '0, 0, 1, 32'h0700_FFFF, 0, 1);
        tick("drop_clr", 0, '0, 0, 0, '0, 0, 1);
        check("drop_clr.zero", drop_cnt, 8'd0);

        // RX full: push with and without rd_en, set beats clear
        for (int i = 0; i < D; i++) tick("rx_fill", 0, '0, 0, 1, 32'h0300_0000 + i, 0, 0);
        tick("rx_full_rd", 0, '0, 0, 1, 32'h03C0_0001, 1, 0);
        check("rx_full_rd.ovf", rx_ovf, 1'b0);
        check("rx_full_rd.count", rx_count, D);
        tick("rx_full_nrd", 0, '0, 0, 1, 32'h03C0_0002, 0, 0);
        check("rx_full_nrd.ovf", rx_ovf, 1'b1);
        tick("rx_ovf_clr_set", 0, '0, 0, 1, 32'hFFC0_0003, 0, 1);
        tick("rx_ovf_clr", 0, '0, 0, 0, '0, 0, 1);
        for (int i = 0; i < D; i++) tick("rx_drain2", 0, '0, 0, 0, '0, 1, 0);

        // Mixed random traffic on both FIFOs
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0: dst = MY_ID;
                1: dst = 8'hFF;
                default: dst = 8'h05;
            endcase
            d = $urandom;
            tick("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), {dst, d[W-9:0]}, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < D; i++) tick("rand_drain", 0, '0, 1, 0, '0, 1, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) tick("pre_rst_tx", 1, 32'hC000_0000 + i, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) tick("pre_rst_rx", 0, '0, 0, 1, 32'h03D0_0000 + i, 0, 0);
        tick("pre_rst_ovf", 0, '0, 0, 1, 32'h0900_0000, 0, 0);
        check("pre_rst.tx_count", tx_count, 5);
        check("pre_rst.rx_count", rx_count, 3);
        #1 reset = 1'b0;
        #1;
        model_clear();
        check_state("async_rst");
        wr_en = 1; wr_data = 32'hDEAD_0001; push = 1; D_push = 32'h03DE_AD01;
        @(posedge clk);
        #1;
        wr_en = 0; push = 0;
        check_state("rst_held");
        @(negedge clk);
        reset = 1'b1;
        tick("post_rst", 1, 32'h0123_4567, 0, 1, 32'hFF00_0042, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_dev_fifo.md
BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

Interface
REQ-001 Parameter: pckg_sz, default 32, packet width in bits; upper 8 bits are the destination ID.
REQ-002 Parameter: depth, default 8, entries per FIFO; power of two, at least 2.
REQ-003 Parameter: id, default 0, this device's 8-bit address.
REQ-004 Parameter: broadcast, default 8'hFF, destination ID accepted by every device.
REQ-005 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  asynchronous active-low reset.
REQ-007 Port: pndng  out  1  TX FIFO non-empty (bus side).
REQ-008 Port: D_pop  out  pckg_sz  TX FIFO head (bus side).
REQ-009 Port: pop  in  1  bus consumes TX head.
REQ-010 Port: push  in  1  bus delivers a packet.
REQ-011 Port: D_push  in  pckg_sz  delivered packet.
REQ-012 Port: wr_en  in  1  host writes a TX packet.
REQ-013 Port: wr_data  in  pckg_sz  host TX packet.
REQ-014 Port: tx_full  out  1  TX FIFO full.
REQ-015 Port: rd_en  in  1  host consumes RX head.
REQ-016 Port: rd_data  out  pckg_sz  RX FIFO head.
REQ-017 Port: rx_valid  out  1  RX FIFO non-empty.
REQ-018 Port: tx_count  out  $clog2(depth+1)  TX occupancy.
REQ-019 Port: rx_count  out  $clog2(depth+1)  RX occupancy.
REQ-020 Port: tx_ovf  out  1  sticky; host wrote while TX full.
REQ-021 Port: rx_ovf  out  1  sticky; accepted packet arrived while RX full.
REQ-022 Port: drop_cnt  out  8  count of address-filtered packets.
REQ-023 Port: err_clr  in  1  clears tx_ovf, rx_ovf and drop_cnt.

Function
REQ-024 Both FIFOs are first-word-fall-through; D_pop/rd_data combinationally show the head entry whenever pndng/rx_valid is 1, value is don't-care otherwise.
REQ-025 TX write: wr_en=1 and tx_full=0 stores wr_data at tail; entry visible on D_pop, pndng=1 the cycle after the write edge (1-cycle latency).
REQ-026 TX pop: pop=1 with pndng=1 advances head; pop with pndng=0 is ignored, no state change.
REQ-027 TX full: wr_en with tx_full=1 and pop=0 discards wr_data, sets tx_ovf; wr_en with tx_full=1 and pop=1 is accepted, tx_count stays depth.
REQ-028 TX empty: wr_en and pop in the same cycle with pndng=0 accepts the write, ignores the pop.
REQ-029 RX filter: push=1 is accepted only if D_push[pckg_sz-1 -: 8] equals id or broadcast; otherwise the packet is discarded and drop_cnt increments, saturating at 255.
REQ-030 RX accept: accepted push with RX not full stores D_push; rx_valid=1 the following cycle.
REQ-031 RX full: accepted push with rx_count=depth and rd_en=0 is discarded and sets rx_ovf; with rd_en=1 it is accepted, rx_count stays depth.
REQ-032 rd_en with rx_valid=0 is ignored.
REQ-033 Pointers wrap modulo depth; counts are exact in 0..depth; tx_full = (tx_count==depth).
REQ-034 err_clr=1 clears sticky flags and drop_cnt next edge; a set/increment in the same cycle wins over clear.
REQ-035 No combinational path from pop/push/wr_en/rd_en to any output.

Reset
REQ-036 reset=0 asynchronously empties both FIFOs: pndng=0, rx_valid=0, tx_full=0, tx_count=0, rx_count=0, tx_ovf=0, rx_ovf=0, drop_cnt=0.
REQ-037 Reset mid-transfer discards all stored packets; no pop/push/wr_en/rd_en has effect while reset=0; operation resumes the first edge after release.

Verification
REQ-038 Write 32'h01AA_0001, 32'h01AA_0002 (id=0) -> pndng=1 after first write, D_pop=32'h01AA_0001; pop -> D_pop=32'h01AA_0002; pop -> pndng=0.
REQ-039 Write 9 packets to depth=8 without pop -> tx_full=1 after 8th, 9th dropped, tx_ovf=1, tx_count=8; write+pop when full -> tx_count=8, tx_ovf unchanged then err_clr -> tx_ovf=0.
REQ-040 id=3: push 32'h03xx_xxxx, 32'hFFxx_xxxx, 32'h05xx_xxxx -> rx_count=2, drop_cnt=1, rd_data=first packet.
REQ-041 Push 256 packets to id 7 with id=0 -> drop_cnt saturates at 255.
REQ-042 Fill RX (8 entries), push with rd_en=1 -> accepted, rx_ovf=0; push with rd_en=0 -> rx_ovf=1.
REQ-043 Assert reset low mid-stream with tx_count=5, rx_count=3 -> all outputs at REQ-036 values immediately, before next clk edge.
